mux_cl_scan_seq: RTL and testbench

- Sequential front end for the 8:1 mux_cl stage.
- Accepts 8-bit parallel words over a valid/ready handshake and holds each word on the mux data inputs (pi00..pi07).
- Sweeps the 3-bit mux select (pi08 = sel[0], pi09 = sel[1], pi10 = sel[2]) and returns the mux output (po0) as a serial bit stream with its own valid/ready/last handshake.

---
 rtl/mux_cl_pkg.sv | 26 ++
 rtl/mux_cl.sv | 28 ++
 rtl/mux_cl_sel_cnt.sv | 34 +++
 rtl/mux_cl_scan_seq.sv | 128 ++++++++++++
 tb/tb_mux_cl_scan_seq.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_cl_pkg.sv
// rtl/mux_cl_pkg.sv - shared constants, state type and select helpers for the mux_cl scan front end
// Contents:
//   MUXCL_SEL_W / MUXCL_DATA_W : select and data widths of the 8:1 mux_cl stage
//   scan_state_t               : scan sequencer states (PARITY used only with MUX_CL_SCAN_PARITY_EN)
//   sel_start / sel_term       : first and last select value for a given scan direction
package mux_cl_pkg;

  localparam int MUXCL_SEL_W  = 3;
  localparam int MUXCL_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } scan_state_t;

  // Ascending scans start at 0 and end at all-ones; descending scans the reverse.
  function automatic logic [MUXCL_SEL_W-1:0] sel_start(input logic msb_first);
    return msb_first ? {MUXCL_SEL_W{1'b1}} : {MUXCL_SEL_W{1'b0}};
  endfunction

  function automatic logic [MUXCL_SEL_W-1:0] sel_term(input logic msb_first);
    return msb_first ? {MUXCL_SEL_W{1'b0}} : {MUXCL_SEL_W{1'b1}};
  endfunction

endpackage

// File: rtl/mux_cl.sv
// rtl/mux_cl.sv - combinational 8:1 mux stage driven by the scan front end
// Ports:
//   pi00..pi07 : data inputs
//   pi08..pi10 : select, pi08 = sel[0], pi10 = sel[2]
//   po0        : selected data bit
module mux_cl (
  input  logic pi00,
  input  logic pi01,
  input  logic pi02,
  input  logic pi03,
  input  logic pi04,
  input  logic pi05,
  input  logic pi06,
  input  logic pi07,
  input  logic pi08,
  input  logic pi09,
  input  logic pi10,
  output logic po0
);

  logic [7:0] data;
  logic [2:0] sel;

  assign data = {pi07, pi06, pi05, pi04, pi03, pi02, pi01, pi00};
  assign sel  = {pi10, pi09, pi08};
  assign po0  = data[sel];

endmodule

// File: rtl/mux_cl_sel_cnt.sv
// rtl/mux_cl_sel_cnt.sv - loadable up/down select counter with terminal flag
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (counter resets to START)
//   load       : reload START (takes priority over en)
//   en         : step one position toward TERM (modulo 2**SEL_W)
//   cnt        : current select value
//   term       : cnt equals TERM
module mux_cl_sel_cnt #(
  parameter int               SEL_W = 3,
  parameter bit               DOWN  = 1'b0,
  parameter logic [SEL_W-1:0] START = '0,
  parameter logic [SEL_W-1:0] TERM  = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  output logic [SEL_W-1:0] cnt,
  output logic             term
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= START;
    end else if (load) begin
      cnt <= START;
    end else if (en) begin
      cnt <= DOWN ? cnt - SEL_W'(1) : cnt + SEL_W'(1);
    end
  end

  assign term = (cnt == TERM);

endmodule

// File: rtl/mux_cl_scan_seq.sv
// rtl/mux_cl_scan_seq.sv - parallel-in, serial-out sequencer sweeping the mux_cl select
// Optional feature macro: MUX_CL_SCAN_PARITY_EN (adds an even-parity beat after each word)
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   in_valid, in_data, in_ready : parallel word handshake
//   mux_data, mux_sel           : held word and select driven to mux_cl
//   mux_po                      : mux_cl output, returned combinationally
//   ser_valid, ser_bit,
//   ser_last, ser_ready         : serial bit stream handshake
module mux_cl_scan_seq
  import mux_cl_pkg::*;
#(
  parameter int DATA_W    = MUXCL_DATA_W,
  parameter int SEL_W     = MUXCL_SEL_W,
  parameter int MSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] mux_data,
  output logic [SEL_W-1:0]  mux_sel,
  input  logic              mux_po,
  output logic              ser_valid,
  output logic              ser_bit,
  output logic              ser_last,
  input  logic              ser_ready
);

  localparam logic [SEL_W-1:0] SEL_START = SEL_W'(sel_start(MSB_FIRST != 0));
  localparam logic [SEL_W-1:0] SEL_TERM  = SEL_W'(sel_term(MSB_FIRST != 0));

  scan_state_t state, state_nxt;
  logic        accept;
  logic        sel_en;
  logic        sel_at_term;

  mux_cl_sel_cnt #(
    .SEL_W (SEL_W),
    .DOWN  (MSB_FIRST != 0),
    .START (SEL_START),
    .TERM  (SEL_TERM)
  ) u_sel_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .en    (sel_en),
    .cnt   (mux_sel),
    .term  (sel_at_term)
  );

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_data <= '0;
    end else if (accept) begin
      mux_data <= in_data;
    end
  end

  // in_ready is raised on the accepted final beat so a new word can be
  // captured in the same cycle, keeping the serial stream gap-free.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    ser_bit   = 1'b0;
    ser_last  = 1'b0;
    sel_en    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        ser_valid = 1'b1;
        ser_bit   = mux_po;
`ifdef MUX_CL_SCAN_PARITY_EN
        if (ser_ready) begin
          if (sel_at_term) begin
            state_nxt = PARITY;
          end else begin
            sel_en = 1'b1;
          end
        end
`else
        ser_last = sel_at_term;
        if (ser_ready) begin
          if (sel_at_term) begin
            // Select stays on its terminal value; only a reload moves it.
            in_ready  = 1'b1;
            state_nxt = in_valid ? SHIFT : IDLE;
          end else begin
            sel_en = 1'b1;
          end
        end
`endif
      end
`ifdef MUX_CL_SCAN_PARITY_EN
      PARITY: begin
        ser_valid = 1'b1;
        ser_bit   = ^mux_data;
        ser_last  = 1'b1;
        if (ser_ready) begin
          in_ready  = 1'b1;
          state_nxt = in_valid ? SHIFT : IDLE;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mux_cl_scan_seq.sv
// tb/tb_mux_cl_scan_seq.sv - directed self-checking bench for mux_cl_scan_seq (LSB-first and MSB-first instances)
module tb_mux_cl_scan_seq;

`ifdef MUX_CL_SCAN_PARITY_EN
  localparam int BEATS = 9;
`else
  localparam int BEATS = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       ser_ready;

  logic       a_in_ready, a_mux_po, a_ser_valid, a_ser_bit, a_ser_last;
  logic [7:0] a_mux_data;
  logic [2:0] a_mux_sel;
  logic       b_in_ready, b_mux_po, b_ser_valid, b_ser_bit, b_ser_last;
  logic [7:0] b_mux_data;
  logic [2:0] b_mux_sel;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux_cl_scan_seq #(.DATA_W(8), .SEL_W(3), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(a_in_ready), .mux_data(a_mux_data), .mux_sel(a_mux_sel),
    .mux_po(a_mux_po), .ser_valid(a_ser_valid), .ser_bit(a_ser_bit),
    .ser_last(a_ser_last), .ser_ready(ser_ready)
  );

  mux_cl mux_lsb (
    .pi00(a_mux_data[0]), .pi01(a_mux_data[1]), .pi02(a_mux_data[2]), .pi03(a_mux_data[3]),
    .pi04(a_mux_data[4]), .pi05(a_mux_data[5]), .pi06(a_mux_data[6]), .pi07(a_mux_data[7]),
    .pi08(a_mux_sel[0]), .pi09(a_mux_sel[1]), .pi10(a_mux_sel[2]), .po0(a_mux_po)
  );

  mux_cl_scan_seq #(.DATA_W(8), .SEL_W(3), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(b_in_ready), .mux_data(b_mux_data), .mux_sel(b_mux_sel),
    .mux_po(b_mux_po), .ser_valid(b_ser_valid), .ser_bit(b_ser_bit),
    .ser_last(b_ser_last), .ser_ready(ser_ready)
  );

  mux_cl mux_msb (
    .pi00(b_mux_data[0]), .pi01(b_mux_data[1]), .pi02(b_mux_data[2]), .pi03(b_mux_data[3]),
    .pi04(b_mux_data[4]), .pi05(b_mux_data[5]), .pi06(b_mux_data[6]), .pi07(b_mux_data[7]),
    .pi08(b_mux_sel[0]), .pi09(b_mux_sel[1]), .pi10(b_mux_sel[2]), .po0(b_mux_po)
  );

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; ser_ready = 1'b1;
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", a_in_ready); end
    checks++; if (a_ser_valid !== 1'b0) begin errors++; $display("FAIL reset_ser_valid got=%b exp=0", a_ser_valid); end
    checks++; if (a_ser_last !== 1'b0) begin errors++; $display("FAIL reset_ser_last got=%b exp=0", a_ser_last); end
    checks++; if (a_mux_sel !== 3'd0) begin errors++; $display("FAIL reset_sel_lsb got=%0d exp=0", a_mux_sel); end
    checks++; if (a_mux_data !== 8'h00) begin errors++; $display("FAIL reset_mux_data got=%h exp=00", a_mux_data); end
    checks++; if (b_mux_sel !== 3'd7) begin errors++; $display("FAIL reset_sel_msb got=%0d exp=7", b_mux_sel); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b1 || a_ser_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle got ready=%b valid=%b exp ready=1 valid=0", a_in_ready, a_ser_valid);
    end
    @(posedge clk); #1;
  endtask

  // Word 0xA5 on both instances: the pattern reads the same in either direction.
  task automatic test_single_word();
    logic [8:0] exp_bits;
    logic [2:0] es;
    exp_bits = 9'b10100101_0;
    in_valid = 1'b1; in_data = 8'hA5; ser_ready = 1'b1;
    @(negedge clk);
    checks++; if (a_ser_valid !== 1'b0) begin errors++; $display("FAIL single_pre_valid got=%b exp=0", a_ser_valid); end
    @(posedge clk); #1 in_valid = 1'b0; in_data = 8'h00;
    for (int k = 0; k < BEATS; k++) begin
      @(negedge clk);
      es = (k < 8) ? 3'(k) : 3'd7;
      checks++; if (a_ser_valid !== 1'b1 || a_ser_bit !== exp_bits[8-k]) begin
        errors++; $display("FAIL single_lsb_bit beat=%0d got valid=%b bit=%b exp valid=1 bit=%b", k, a_ser_valid, a_ser_bit, exp_bits[8-k]);
      end
      checks++; if (a_mux_sel !== es) begin errors++; $display("FAIL single_lsb_sel beat=%0d got=%0d exp=%0d", k, a_mux_sel, es); end
      checks++; if (a_ser_last !== (k == BEATS-1)) begin errors++; $display("FAIL single_last beat=%0d got=%b exp=%b", k, a_ser_last, k == BEATS-1); end
      checks++; if (a_in_ready !== (k == BEATS-1)) begin errors++; $display("FAIL single_in_ready beat=%0d got=%b exp=%b", k, a_in_ready, k == BEATS-1); end
      checks++; if (b_ser_bit !== exp_bits[8-k]) begin errors++; $display("FAIL single_msb_bit beat=%0d got=%b exp=%b", k, b_ser_bit, exp_bits[8-k]); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (a_ser_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      errors++; $display("FAIL single_end_idle got valid=%b ready=%b exp valid=0 ready=1", a_ser_valid, a_in_ready);
    end
    @(posedge clk); #1;
  endtask

  // Word 0x01 on the descending instance: seven zeros then a one, select 7 down to 0.
  task automatic test_msb_first();
    logic [8:0] exp_bits;
    logic [2:0] es;
    exp_bits = 9'b00000001_1;
    in_valid = 1'b1; in_data = 8'h01; ser_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      @(negedge clk);
      es = (k < 8) ? 3'(7 - k) : 3'd0;
      checks++; if (b_ser_valid !== 1'b1 || b_ser_bit !== exp_bits[8-k]) begin
        errors++; $display("FAIL msb_bit beat=%0d got valid=%b bit=%b exp valid=1 bit=%b", k, b_ser_valid, b_ser_bit, exp_bits[8-k]);
      end
      checks++; if (b_mux_sel !== es) begin errors++; $display("FAIL msb_sel beat=%0d got=%0d exp=%0d", k, b_mux_sel, es); end
      checks++; if (b_ser_last !== (k == BEATS-1)) begin errors++; $display("FAIL msb_last beat=%0d got=%b exp=%b", k, b_ser_last, k == BEATS-1); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (b_ser_valid !== 1'b0) begin errors++; $display("FAIL msb_end_valid got=%b exp=0", b_ser_valid); end
    @(posedge clk); #1;
  endtask

  // 0x0F then 0xF0 with in_valid held: contiguous beats, ready only on each final beat.
  task automatic test_back_to_back();
    logic [17:0] exp_bits;
    logic        exp_edge;
`ifdef MUX_CL_SCAN_PARITY_EN
    exp_bits = 18'b11110000_0_00001111_0;
`else
    exp_bits = 18'b00_11110000_00001111;
`endif
    in_valid = 1'b1; in_data = 8'h0F; ser_ready = 1'b1;
    @(posedge clk); #1 in_data = 8'hF0;
    for (int k = 0; k < 2*BEATS; k++) begin
      @(negedge clk);
      exp_edge = (k == BEATS-1) || (k == 2*BEATS-1);
      checks++; if (a_ser_valid !== 1'b1 || a_ser_bit !== exp_bits[2*BEATS-1-k]) begin
        errors++; $display("FAIL b2b_bit beat=%0d got valid=%b bit=%b exp valid=1 bit=%b", k, a_ser_valid, a_ser_bit, exp_bits[2*BEATS-1-k]);
      end
      checks++; if (a_in_ready !== exp_edge) begin errors++; $display("FAIL b2b_in_ready beat=%0d got=%b exp=%b", k, a_in_ready, exp_edge); end
      checks++; if (a_ser_last !== exp_edge) begin errors++; $display("FAIL b2b_last beat=%0d got=%b exp=%b", k, a_ser_last, exp_edge); end
      @(posedge clk); #1;
      if (k == BEATS-1) begin
        in_valid = 1'b0; in_data = 8'h00;
      end
    end
    @(negedge clk);
    checks++; if (a_ser_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got=%b exp=0", a_ser_valid); end
    @(posedge clk); #1;
  endtask

  // 0x3C with ser_ready low on cycles 3..5: the third beat is held for three extra cycles.
  task automatic test_backpressure();
    logic [8:0] exp_bits;
    logic [2:0] es;
    int         k;
    exp_bits = 9'b00111100_0;
    k = 0;
    in_valid = 1'b1; in_data = 8'h3C; ser_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; in_data = 8'hFF;
    for (int c = 0; c < BEATS + 3; c++) begin
      ser_ready = !(c >= 2 && c <= 4);
      @(negedge clk);
      es = (k < 8) ? 3'(k) : 3'd7;
      checks++; if (a_ser_valid !== 1'b1 || a_ser_bit !== exp_bits[8-k]) begin
        errors++; $display("FAIL bp_bit cycle=%0d got valid=%b bit=%b exp valid=1 bit=%b", c, a_ser_valid, a_ser_bit, exp_bits[8-k]);
      end
      checks++; if (a_mux_sel !== es) begin errors++; $display("FAIL bp_sel cycle=%0d got=%0d exp=%0d", c, a_mux_sel, es); end
      checks++; if (a_ser_last !== (k == BEATS-1)) begin errors++; $display("FAIL bp_last cycle=%0d got=%b exp=%b", c, a_ser_last, k == BEATS-1); end
      checks++; if (a_in_ready !== (ser_ready && k == BEATS-1)) begin
        errors++; $display("FAIL bp_in_ready cycle=%0d got=%b exp=%b", c, a_in_ready, ser_ready && k == BEATS-1);
      end
      @(posedge clk); #1;
      if (ser_ready) k++;
    end
    ser_ready = 1'b1;
    @(negedge clk);
    checks++; if (a_ser_valid !== 1'b0 || a_mux_data !== 8'h3C) begin
      errors++; $display("FAIL bp_end got valid=%b data=%h exp valid=0 data=3c", a_ser_valid, a_mux_data);
    end
    @(posedge clk); #1;
  endtask

  // 0xFF interrupted by reset on its fourth beat.
  task automatic test_reset_mid_word();
    in_valid = 1'b1; in_data = 8'hFF; ser_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; in_data = 8'h00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (a_ser_valid !== 1'b1 || a_ser_bit !== 1'b1) begin
        errors++; $display("FAIL rst_mid_pre beat=%0d got valid=%b bit=%b exp valid=1 bit=1", k, a_ser_valid, a_ser_bit);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (a_mux_sel !== 3'd3 || a_ser_valid !== 1'b1) begin
      errors++; $display("FAIL rst_mid_beat4 got sel=%0d valid=%b exp sel=3 valid=1", a_mux_sel, a_ser_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (a_ser_valid !== 1'b0 || b_ser_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_async_valid got lsb=%b msb=%b exp 0", a_ser_valid, b_ser_valid);
    end
    checks++; if (a_mux_data !== 8'h00 || a_mux_sel !== 3'd0 || a_in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_async_state got data=%h sel=%0d ready=%b exp data=00 sel=0 ready=1", a_mux_data, a_mux_sel, a_in_ready);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++; if (a_ser_valid !== 1'b0 || a_in_ready !== 1'b1) begin
        errors++; $display("FAIL rst_mid_residual cycle=%0d got valid=%b ready=%b exp valid=0 ready=1", c, a_ser_valid, a_in_ready);
      end
      @(posedge clk); #1;
    end
  endtask

  // 0x07: odd popcount, so the parity beat (when built in) carries a one.
  task automatic test_parity();
    logic [8:0] exp_bits;
    exp_bits = 9'b11100000_1;
    in_valid = 1'b1; in_data = 8'h07; ser_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      @(negedge clk);
      checks++; if (a_ser_valid !== 1'b1 || a_ser_bit !== exp_bits[8-k]) begin
        errors++; $display("FAIL parity_word_bit beat=%0d got valid=%b bit=%b exp valid=1 bit=%b", k, a_ser_valid, a_ser_bit, exp_bits[8-k]);
      end
      checks++; if (a_ser_last !== (k == BEATS-1)) begin errors++; $display("FAIL parity_word_last beat=%0d got=%b exp=%b", k, a_ser_last, k == BEATS-1); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (a_ser_valid !== 1'b0) begin errors++; $display("FAIL parity_word_end got=%b exp=0", a_ser_valid); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_msb_first();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_parity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
